// File: rtl/inst_fetch.sv
// Instruction fetch unit with an integrated instruction queue feeding decode.
// Define IFETCH_JAL_PREDICT_EN to follow JAL targets locally instead of stalling for commit.
module inst_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          IQ_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        iq_ready,
  output logic        halted
);

  localparam int          DEPTH    = 1 << IQ_DEPTH_LOG;
  localparam logic [31:0] END_INST = 32'h0ff00513;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, STALL, HALT} state_t;

  state_t                  state, state_n;
  logic [31:0]             pc, pc_n, req_addr_n;
  logic                    req_valid_n, halted_n, push, pop;
  logic [IQ_DEPTH_LOG-1:0] head, tail;
  logic [IQ_DEPTH_LOG:0]   count;
  logic [63:0]             iq_mem [DEPTH];

`ifdef IFETCH_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{12{mem_resp_data[31]}}, mem_resp_data[19:12], mem_resp_data[20],
                    mem_resp_data[30:21], 1'b0};
`endif

  assign iq_valid          = (count != '0);
  assign {iq_inst, iq_pc}  = iq_mem[head];
  assign pop               = iq_valid && iq_ready && !flush_in;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_valid_n = mem_req_valid;
    req_addr_n  = mem_req_addr;
    halted_n    = halted;
    push        = 1'b0;
    if (flush_in) begin
      pc_n        = flush_pc;
      halted_n    = 1'b0;
      req_valid_n = 1'b0;
      // A request still owed a response must have that response swallowed first.
      if ((state == REQ && mem_req_ready) ||
          ((state == WAIT || state == DROP) && !mem_resp_valid))
        state_n = DROP;
      else
        state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!count[IQ_DEPTH_LOG]) begin
            req_valid_n = 1'b1;
            req_addr_n  = pc;
            state_n     = REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            req_valid_n = 1'b0;
            state_n     = WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            push = 1'b1;
            if (mem_resp_data == END_INST) begin
              halted_n = 1'b1;
              state_n  = HALT;
            end else if (mem_resp_data[6:0] == OP_JAL) begin
`ifdef IFETCH_JAL_PREDICT_EN
              pc_n    = pc + jal_imm;
              state_n = IDLE;
`else
              state_n = STALL;
`endif
            end else begin
              pc_n    = pc + 32'd4;
              state_n = IDLE;
            end
          end
        end
        DROP: begin
          if (mem_resp_valid) state_n = IDLE;
        end
        STALL, HALT: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= RESET_PC;
      halted        <= 1'b0;
    end else if (rdy_in) begin
      state         <= state_n;
      pc            <= pc_n;
      mem_req_valid <= req_valid_n;
      mem_req_addr  <= req_addr_n;
      halted        <= halted_n;
    end
  end

  // Queue pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + IQ_DEPTH_LOG'(1);
        if (pop)  head <= head + IQ_DEPTH_LOG'(1);
        case ({push, pop})
          2'b10:   count <= count + (IQ_DEPTH_LOG+1)'(1);
          2'b01:   count <= count - (IQ_DEPTH_LOG+1)'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) iq_mem[tail] <= {mem_resp_data, pc};
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: randomized memory responder plus a
// program-level scoreboard of expected fetch addresses and queue pops.
module tb_inst_fetch;

  localparam logic [31:0] END_INST = 32'h0ff00513;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush_in = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_ready = 1'b0;
  logic        halted;

  always #5 clk_in = ~clk_in;

  inst_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .flush_in(flush_in), .flush_pc(flush_pc),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_ready(iq_ready),
    .halted(halted)
  );

  // Program image: kind 0 = plain, 1 = JAL (offset in joff), 2 = end instruction.
  logic [31:0] imem [256];
  int          kind [256];
  int          joff [256];

  int checks = 0;
  int errors = 0;

  int lat = 1;
  int ready_pct = 100;
  int stall_pct = 0;

  logic [31:0] req_log [$];
  logic [31:0] req_hist [$];
  bit          pend;
  int          cd;
  logic [31:0] paddr;

  logic [31:0] pop_pc, req_pc, mon_a;
  bit          pop_done, req_done;

  function automatic logic [31:0] jal_enc(logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  // Program-order successor of a fetched PC; d marks that fetching stops.
  function automatic void adv(inout logic [31:0] p, inout bit d);
    int idx;
    idx = int'(p[9:2]);
    if (kind[idx] == 2) d = 1'b1;
    else if (kind[idx] == 1) begin
`ifdef IFETCH_JAL_PREDICT_EN
      p = p + 32'(joff[idx]);
`else
      d = 1'b1;
`endif
    end else p = p + 32'd4;
  endfunction

  function automatic logic [31:0] hist_at(int i);
    if (i < req_hist.size()) return req_hist[i];
    return 32'hdead_beef;
  endfunction

  task automatic load_plain();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      w[6:0] = 7'b0110011;
      imem[i] = w;
      kind[i] = 0;
      joff[i] = 0;
    end
  endtask

  task automatic set_jal(int idx, int off);
    imem[idx] = jal_enc(21'(off));
    kind[idx] = 1;
    joff[idx] = off;
  endtask

  task automatic set_end(int idx);
    imem[idx] = END_INST;
    kind[idx] = 2;
  endtask

  // Memory controller: one request at a time, configurable latency and back-pressure.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    rdy_in         = 1'b1;
    pend           = 1'b0;
    cd             = 0;
    paddr          = '0;
    forever begin
      @(negedge clk_in);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      if (rst_in) begin
        pend   = 1'b0;
        rdy_in = 1'b1;
      end else begin
        rdy_in = ($urandom_range(99) >= stall_pct);
        if (rdy_in) begin
          if (pend) begin
            if (cd == 0) begin
              mem_resp_valid = 1'b1;
              mem_resp_data  = imem[paddr[9:2]];
              pend           = 1'b0;
            end else cd--;
          end else if (mem_req_valid && $urandom_range(99) < ready_pct) begin
            mem_req_ready = 1'b1;
            pend          = 1'b1;
            paddr         = mem_req_addr;
            cd            = (lat == 0) ? int'($urandom_range(3)) : lat - 1;
            req_log.push_back(mem_req_addr);
            req_hist.push_back(mem_req_addr);
          end
        end
      end
    end
  end

  // Scoreboard: every accepted request and every pop must follow program order.
  initial begin
    pop_pc = '0; req_pc = '0; pop_done = 1'b0; req_done = 1'b0; mon_a = '0;
    forever begin
      @(negedge clk_in);
      #3;
      if (rst_in) begin
        pop_pc = '0; req_pc = '0; pop_done = 1'b0; req_done = 1'b0;
        req_log.delete();
      end else if (rdy_in) begin
        while (req_log.size() > 0) begin
          mon_a = req_log.pop_front();
          checks++;
          if (req_done || mon_a !== req_pc) begin
            errors++;
            $display("[TB] FAIL req_addr got %h exp %h unexpected=%0d", mon_a, req_pc, req_done);
          end
          if (!req_done) adv(req_pc, req_done);
        end
        if (flush_in) begin
          pop_pc = flush_pc; req_pc = flush_pc; pop_done = 1'b0; req_done = 1'b0;
        end else if (iq_valid && iq_ready) begin
          checks++;
          if (pop_done || iq_pc !== pop_pc || iq_inst !== imem[pop_pc[9:2]]) begin
            errors++;
            $display("[TB] FAIL pop got pc=%h inst=%h exp pc=%h inst=%h unexpected=%0d",
                     iq_pc, iq_inst, pop_pc, imem[pop_pc[9:2]], pop_done);
          end
          if (!pop_done) adv(pop_pc, pop_done);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; flush_in = 1'b0; iq_ready = 1'b0;
    tick(); tick();
    req_hist.delete();
    rst_in = 1'b0;
  endtask

  task automatic run(int n, int pop_pct);
    for (int i = 0; i < n; i++) begin
      iq_ready = ($urandom_range(99) < pop_pct);
      tick();
    end
    iq_ready = 1'b0;
  endtask

  task automatic do_flush(logic [31:0] target);
    flush_in = 1'b1; flush_pc = target; iq_ready = 1'b0;
    tick();
    flush_in = 1'b0;
  endtask

  task automatic test_reset();
    load_plain();
    lat = 1; ready_pct = 100; stall_pct = 0;
    do_reset();
    run(30, 0);
    rst_in = 1'b1;
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %b exp 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_req_addr got %h exp 0", mem_req_addr); end
    checks++; if (iq_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_iq_valid got %b exp 0", iq_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b exp 0", halted); end
  endtask

  task automatic test_first_fetch();
    bit seen;
    seen = 1'b0;
    req_hist.delete();
    rst_in = 1'b0; iq_ready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_resp_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL first_resp got none exp response within 20 cycles"); end
    checks++; if (iq_valid !== 1'b0) begin errors++; $display("[TB] FAIL iq_valid_early got %b exp 0", iq_valid); end
    tick();
    checks++; if (iq_valid !== 1'b1) begin errors++; $display("[TB] FAIL iq_valid_rise got %b exp 1", iq_valid); end
    run(20, 0);
    checks++; if (hist_at(0) !== 32'h0) begin errors++; $display("[TB] FAIL first_req0 got %h exp 0", hist_at(0)); end
    checks++; if (hist_at(1) !== 32'h4) begin errors++; $display("[TB] FAIL first_req1 got %h exp 4", hist_at(1)); end
    checks++; if (hist_at(2) !== 32'h8) begin errors++; $display("[TB] FAIL first_req2 got %h exp 8", hist_at(2)); end
    checks++; if (iq_pc !== 32'h0) begin errors++; $display("[TB] FAIL head_pc got %h exp 0", iq_pc); end
    run(20, 100);
  endtask

  task automatic test_full_queue();
    do_reset();
    run(100, 0);
    checks++; if (req_hist.size() != 8) begin errors++; $display("[TB] FAIL full_req_count got %0d exp 8", req_hist.size()); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_req_valid got %b exp 0", mem_req_valid); end
    checks++; if (iq_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_iq_valid got %b exp 1", iq_valid); end
    iq_ready = 1'b1;
    tick();
    iq_ready = 1'b0;
    run(20, 0);
    checks++; if (req_hist.size() != 9) begin errors++; $display("[TB] FAIL refill_req_count got %0d exp 9", req_hist.size()); end
    checks++; if (hist_at(8) !== 32'h20) begin errors++; $display("[TB] FAIL refill_addr got %h exp 20", hist_at(8)); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL refill_req_valid got %b exp 0", mem_req_valid); end
  endtask

  task automatic test_flush_wait();
    int n0, n1;
    bit stale;
    do_reset();
    run(20, 0);
    lat = 6;
    n0 = req_hist.size();
    for (int i = 0; i < 20 && req_hist.size() == n0; i++) tick();
    checks++; if (req_hist.size() == n0) begin errors++; $display("[TB] FAIL flush_accept got none exp accepted request"); end
    tick();
    do_flush(32'h100);
    lat = 1;
    checks++; if (iq_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_clear got %b exp 0", iq_valid); end
    n1 = req_hist.size();
    stale = 1'b0;
    for (int i = 0; i < 30 && req_hist.size() == n1; i++) begin
      tick();
      if (iq_valid) stale = 1'b1;
    end
    checks++; if (hist_at(n1) !== 32'h100) begin errors++; $display("[TB] FAIL flush_target got %h exp 100", hist_at(n1)); end
    checks++; if (stale) begin errors++; $display("[TB] FAIL stale_drop got 1 exp 0"); end
    run(20, 100);
  endtask

  task automatic test_jal();
    load_plain();
    set_jal(4, 64);
    do_reset();
    run(60, 100);
`ifdef IFETCH_JAL_PREDICT_EN
    checks++; if (hist_at(5) !== 32'h50) begin errors++; $display("[TB] FAIL jal_target got %h exp 50", hist_at(5)); end
`else
    checks++; if (req_hist.size() != 5) begin errors++; $display("[TB] FAIL jal_stall_count got %0d exp 5", req_hist.size()); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL jal_stall_valid got %b exp 0", mem_req_valid); end
    do_flush(32'h50);
    run(20, 100);
    checks++; if (hist_at(5) !== 32'h50) begin errors++; $display("[TB] FAIL jal_resume got %h exp 50", hist_at(5)); end
`endif
  endtask

  task automatic test_neg_jal();
    load_plain();
    set_jal(2, -8);
    do_reset();
    run(60, 100);
`ifdef IFETCH_JAL_PREDICT_EN
    checks++; if (hist_at(3) !== 32'h0) begin errors++; $display("[TB] FAIL neg_jal_target got %h exp 0", hist_at(3)); end
    checks++; if (hist_at(6) !== 32'h0) begin errors++; $display("[TB] FAIL neg_jal_loop got %h exp 0", hist_at(6)); end
`else
    checks++; if (req_hist.size() != 3) begin errors++; $display("[TB] FAIL neg_jal_stall got %0d exp 3", req_hist.size()); end
`endif
  endtask

  task automatic test_end_halt();
    load_plain();
    set_end(3);
    do_reset();
    run(40, 100);
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag got %b exp 1", halted); end
    checks++; if (req_hist.size() != 4) begin errors++; $display("[TB] FAIL halt_req_count got %0d exp 4", req_hist.size()); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_req_valid got %b exp 0", mem_req_valid); end
    do_flush(32'h0);
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_clear got %b exp 0", halted); end
    run(20, 100);
    checks++; if (hist_at(4) !== 32'h0) begin errors++; $display("[TB] FAIL halt_resume got %h exp 0", hist_at(4)); end
  endtask

  task automatic test_random();
    logic        s_v, s_iv, s_h, frz;
    logic [31:0] s_addr, s_pc;
    int          r;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(99));
      if (r < 8) set_jal(i, (int'($urandom_range(64)) - 32) * 4);
      else if (r < 11) set_end(i);
    end
    lat = 0; ready_pct = 70; stall_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      iq_ready = ($urandom_range(99) < 60);
      flush_in = 1'b0;
      if (rdy_in && $urandom_range(99) < 2) begin
        flush_in = 1'b1;
        flush_pc = 32'($urandom_range(255)) << 2;
      end
      frz = !rdy_in;
      s_v = mem_req_valid; s_addr = mem_req_addr; s_iv = iq_valid; s_pc = iq_pc; s_h = halted;
      tick();
      if (frz) begin
        checks++;
        if ({mem_req_valid, mem_req_addr, iq_valid, iq_pc, halted} !== {s_v, s_addr, s_iv, s_pc, s_h}) begin
          errors++;
          $display("[TB] FAIL freeze got v=%b a=%h iv=%b pc=%h h=%b exp v=%b a=%h iv=%b pc=%h h=%b",
                   mem_req_valid, mem_req_addr, iq_valid, iq_pc, halted, s_v, s_addr, s_iv, s_pc, s_h);
        end
      end
    end
    flush_in = 1'b0; iq_ready = 1'b0; stall_pct = 0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_full_queue();
    test_flush_wait();
    test_jal();
    test_neg_jal();
    test_end_halt();
    test_random();
    run(5, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit with an integrated instruction queue, sitting directly upstream of the instruction decoder. It sequences the PC, issues one-at-a-time word fetches to the memory controller, buffers returned instructions with their PCs in a FIFO, and presents the queue head to decode/issue. It redirects on JAL, halts after the program-end instruction `0x0ff00513`, and discards all state on a pipeline flush.

## Interface
- `RESET_PC`, default `32'h0`: PC loaded on reset.
- `IQ_DEPTH_LOG`, default `3`: queue depth is 2^IQ_DEPTH_LOG entries (8).
- `clk_in` in 1: the only clock; all state changes on its rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global enable; when low, no register updates.
- `mem_req_valid` out 1: fetch request pending.
- `mem_req_addr` out 32: fetch address.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_resp_valid` in 1: returned instruction valid this cycle.
- `mem_resp_data` in 32: returned instruction word.
- `flush_in` in 1: redirect/flush from commit.
- `flush_pc` in 32: new PC when `flush_in` is high.
- `iq_valid` out 1: queue non-empty.
- `iq_inst` out 32: head instruction, fed to decoder `inst`.
- `iq_pc` out 32: PC of the head instruction.
- `iq_ready` in 1: consumer pops the head this cycle.
- `halted` out 1: fetch stopped after the end instruction.

## Operation
- **Reset values:**
  - pc = RESET_PC, state IDLE.
  - `mem_req_valid` = 0, `mem_req_addr` = RESET_PC.
  - queue head/tail/count = 0, so `iq_valid` = 0.
  - `halted` = 0.
- **States:** IDLE, REQ, WAIT, DROP, STALL, HALT.
- **IDLE:** if count < 2^IQ_DEPTH_LOG, set `mem_req_valid` = 1 and `mem_req_addr` = pc, then go to REQ. Otherwise stay.
- **REQ:** hold valid and addr stable until `mem_req_ready`. Then clear valid and go to WAIT.
- **WAIT:** on `mem_resp_valid`, push {data, pc}.
  - If data == `0x0ff00513`: go to HALT, set `halted` = 1.
  - Else if opcode == `7'b1101111` (JAL): see Configuration.
  - Else: pc = pc + 4, go to IDLE.
- **DROP:** wait for the response of an abandoned request, discard it, go to IDLE.
- **STALL / HALT:** no requests are issued. Queue pops continue.
- **Only one request is ever outstanding.** Space is checked before the request is issued, so a response push never overflows the queue.
- **Queue:**
  - Circular buffer with power-of-two wrap of head and tail. Count is IQ_DEPTH_LOG+1 bits wide.
  - `iq_valid` = (count != 0); `iq_inst`/`iq_pc` = entry at head (combinational read).
  - Pop when `iq_valid && iq_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - `iq_ready` while empty has no effect.
- **Flush (`flush_in` = 1):** highest priority.
  - Queue cleared (count, head, tail = 0); same-cycle push and pop are ignored.
  - pc = `flush_pc`, `halted` = 0, `mem_req_valid` = 0.
  - Next state is DROP if a request is in flight: state WAIT, or REQ with `mem_req_ready` high in that cycle. Otherwise IDLE.
  - A `mem_resp_valid` arriving in the flush cycle itself counts as the in-flight response and is dropped; next state is IDLE.
- **Arithmetic:** all PC sums are 32-bit modulo 2^32.

## Timing
- `mem_req_valid` and `mem_req_addr` are registered.
- Flush at cycle t (no request in flight): IDLE at t+1, request for `flush_pc` visible at t+2.
- Response at t with room: pushed at t, `iq_valid` high at t+1; next request visible at t+2.
- Throughput: at best one instruction per (memory latency + 2) cycles.
- Pop at t: new head visible at t+1.
- `rdy_in` = 0 freezes all state and outputs. The memory controller asserts neither `mem_req_ready` nor `mem_resp_valid` while `rdy_in` = 0.

## Configuration
- **`IFETCH_JAL_PREDICT_EN` defined:** on a JAL response, pc = pc + J-imm, where J-imm = {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0}. Go to IDLE. The JAL is still pushed; the decoder writes pc+4 to rd.
- **Not defined:** the JAL is pushed and the unit enters STALL. It leaves STALL only via `flush_in`, with commit supplying the target.

## Test plan
- **Reset/first fetch:** release reset, 1-cycle memory latency, RESET_PC = 0 → requests to 0x0, 0x4, 0x8. Queue holds those PCs in order; `iq_valid` rises one cycle after the first response.
- **Full queue:** hold `iq_ready` = 0 → exactly 8 entries pushed, `mem_req_valid` stays 0. Pulse one pop → exactly one new request, for PC 0x20.
- **Flush in WAIT:** flush to 0x100 while a request is outstanding → stale response discarded, queue empty. Next request address is 0x100.
- **JAL at 0x10 with imm +0x40, macro on:** next request is 0x50. Macro off: no request until flush to 0x50.
- **Negative JAL:** JAL at 0x8 with imm -8, macro on → next request is 0x0 (wrap arithmetic).
- **End instruction:** fetch returns `0x0ff00513` → pushed, `halted` = 1, no further requests. A subsequent flush to 0x0 clears `halted` and resumes fetch.
